seg7_factor_reader: RTL and testbench
=====================================

SEG7_FACTOR_READER -- requirements
Module: seg7_factor_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical samples needed to accept a segment pattern (range 1..255).
REQ-002 Parameter FIFO_DEPTH, default 4: number of digit entries buffered (power of two, 2..16).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 segments  input  7  display segment lines from the factorizer, bit0=a .. bit6=g, active-high.
REQ-006 is_zero  input  1  factorizer zero-input flag.
REQ-007 out_valid  output  1  FIFO head entry available.
REQ-008 out_ready  input  1  consumer accepts head entry when out_valid and out_ready are both high.
REQ-009 out_digit  output  4  decoded hex value of the head entry.
REQ-010 out_zero  output  1  is_zero value captured with the head entry.
REQ-011 pattern_err  output  1  sticky: an accepted pattern matched no hex glyph.
REQ-012 overflow  output  1  sticky: an accepted digit was dropped because the FIFO was full.

Function
REQ-013 Inputs segments and is_zero shall be registered once before all other use (1-cycle input stage).
REQ-014 Decode table (hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71; no other pattern decodes.
REQ-015 Pattern 00 (all segments off) is "blank"; blank is never pushed and never an error.
REQ-016 FSM states BLANK, QUAL, HELD; reset state BLANK.
REQ-017 BLANK: registered pattern non-blank -> QUAL, stability counter loaded to 1, candidate pattern latched.
REQ-018 QUAL: pattern equal to candidate -> counter increments; pattern differs and non-blank -> restart QUAL with new candidate, counter 1; pattern blank -> BLANK.
REQ-019 QUAL: when counter reaches STABLE_CYCLES, the pattern is accepted in that cycle and the FSM enters HELD.
REQ-020 On acceptance: valid glyph -> push {digit, is_zero}; invalid glyph -> no push, pattern_err set.
REQ-021 HELD: pattern equal to accepted value -> stay, no further pushes; blank -> BLANK; different non-blank -> QUAL with new candidate (counter 1).
REQ-022 Consequence: repeated identical factors are only recorded when separated by a blank of any length >= 1 registered cycle.
REQ-023 Latency: with STABLE_CYCLES=N, out_valid rises N+1 cycles after the first segments edge showing a new stable glyph into an empty FIFO.
REQ-024 FIFO: first-in first-out, out_digit/out_zero driven from head register, stable while out_valid and not out_ready.
REQ-025 Push and pop in the same cycle shall both succeed, including when full (count unchanged, no overflow).
REQ-026 Push when full without simultaneous pop: entry dropped, FIFO contents unchanged, overflow set.
REQ-027 Pointers wrap modulo FIFO_DEPTH; occupancy count width clog2(FIFO_DEPTH)+1.
REQ-028 out_ready while out_valid low has no effect.
REQ-029 pattern_err and overflow clear only on rst.

Reset
REQ-030 While rst is high at a clock edge: FSM=BLANK, counter=0, candidate=00, input registers=0, FIFO empty, out_valid=0, out_digit=0, out_zero=0, pattern_err=0, overflow=0.
REQ-031 Reset mid-qualification or with FIFO non-empty discards all in-flight and buffered entries; first push after reset requires a full new qualification.

Structure
REQ-032 Shared package seg7_pkg holds the 16 glyph constants, BLANK pattern constant, and the FSM state enumeration.
REQ-033 The decode table is a combinational function in seg7_pkg returning {valid, digit}.
REQ-034 One sub-module, seg7_fifo (parameterised depth/width, synchronous reset), implements REQ-024..REQ-027.

Verification
REQ-035 STABLE_CYCLES=4: drive 5B for 6 cycles, out_ready=1 -> exactly one entry digit=2, out_valid high 5 cycles after first 5B edge.
REQ-036 Drive 5B 6 cycles, 00 2 cycles, 5B 6 cycles, then 4F 6 cycles, out_ready=1 -> entries 2,2,3 in order.
REQ-037 Drive 4F for 3 cycles then 66 for 6 cycles -> single entry 4, no 3.
REQ-038 Drive 49 (invalid) for 6 cycles -> no entry, pattern_err=1 until rst.
REQ-039 out_ready=0, push 5 digits 1..5 separated by blanks with FIFO_DEPTH=4 -> overflow=1, then draining yields 1,2,3,4; push coinciding with pop at full -> no overflow.
REQ-040 Assert rst for 1 cycle mid-QUAL with 2 entries buffered -> out_valid=0, flags 0 next cycle, held glyph re-accepted only after 4 further stable cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment factor reader: glyph patterns,
// the blank pattern, FSM state encoding and the glyph decode function.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_QUAL  = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  // Returns {valid, digit}; any pattern outside the 16 hex glyphs is invalid.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pattern);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pattern)
      GLYPH_0: res = {1'b1, 4'h0};
      GLYPH_1: res = {1'b1, 4'h1};
      GLYPH_2: res = {1'b1, 4'h2};
      GLYPH_3: res = {1'b1, 4'h3};
      GLYPH_4: res = {1'b1, 4'h4};
      GLYPH_5: res = {1'b1, 4'h5};
      GLYPH_6: res = {1'b1, 4'h6};
      GLYPH_7: res = {1'b1, 4'h7};
      GLYPH_8: res = {1'b1, 4'h8};
      GLYPH_9: res = {1'b1, 4'h9};
      GLYPH_A: res = {1'b1, 4'hA};
      GLYPH_B: res = {1'b1, 4'hB};
      GLYPH_C: res = {1'b1, 4'hC};
      GLYPH_D: res = {1'b1, 4'hD};
      GLYPH_E: res = {1'b1, 4'hE};
      GLYPH_F: res = {1'b1, 4'hF};
      default: res = 5'b0_0000;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_fifo.sv
// Small synchronous FIFO holding decoded digit entries. A push into a full
// FIFO succeeds only when a pop happens in the same cycle; otherwise the
// entry is dropped and reported on 'dropped' for that cycle.
module seg7_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic             dropped
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // Handshake qualification: pop only when non-empty, push when room or popping.
  always_comb begin
    full    = (count == CW'(DEPTH));
    valid   = (count != '0);
    do_pop  = pop && valid;
    do_push = push && (!full || do_pop);
    dropped = push && !do_push;
  end

  assign head_data = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally on power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seg7_factor_reader.sv
// Reads the seven-segment output of a factorizer, waits for each glyph to
// hold steady, decodes it and queues {digit, is_zero} for a consumer.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_BLANK | display dark (or just reset); waiting for any lit pattern
// ST_QUAL  | candidate pattern being counted for stability
// ST_HELD  | candidate accepted; ignore it until it changes or goes blank
module seg7_factor_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  input  logic       is_zero,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_zero,
  output logic       pattern_err,
  output logic       overflow
);

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0] seg_q;
  logic       zero_q;
  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic [6:0] cand;
  logic [6:0] cand_nx;
  logic       accept;
  logic [4:0] dec;
  logic       push;
  logic       dropped;

  // Input stage: one register on the asynchronous display lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q  <= SEG_BLANK;
      zero_q <= 1'b0;
    end else begin
      seg_q  <= segments;
      zero_q <= is_zero;
    end
  end

  // FSM, stability counter and candidate registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      cand  <= SEG_BLANK;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cand  <= cand_nx;
    end
  end

  // Next-state logic; acceptance fires in the cycle the count reaches the
  // threshold, which also covers a threshold of one on the first sample.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    accept   = 1'b0;
    case (state)
      ST_BLANK: begin
        if (seg_q != SEG_BLANK) begin
          state_nx = ST_QUAL;
          cnt_nx   = 8'd1;
          cand_nx  = seg_q;
        end
      end
      ST_QUAL: begin
        if (seg_q == SEG_BLANK) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end else if (seg_q != cand) begin
          cnt_nx  = 8'd1;
          cand_nx = seg_q;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      ST_HELD: begin
        if (seg_q == SEG_BLANK) begin
          state_nx = ST_BLANK;
          cnt_nx   = '0;
        end else if (seg_q != cand) begin
          state_nx = ST_QUAL;
          cnt_nx   = 8'd1;
          cand_nx  = seg_q;
        end
      end
      default: begin
        state_nx = ST_BLANK;
        cnt_nx   = '0;
        cand_nx  = SEG_BLANK;
      end
    endcase
    if (state_nx == ST_QUAL && cnt_nx == STABLE_CNT) begin
      accept   = 1'b1;
      state_nx = ST_HELD;
    end
  end

  // Decode the pattern being accepted this cycle.
  always_comb begin
    dec  = decode_glyph(cand_nx);
    push = accept && dec[4];
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_err <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (accept && !dec[4]) pattern_err <= 1'b1;
      if (dropped)           overflow    <= 1'b1;
    end
  end

  seg7_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({dec[3:0], zero_q}),
    .pop       (out_ready),
    .head_data ({out_digit, out_zero}),
    .valid     (out_valid),
    .dropped   (dropped)
  );

endmodule

// File: tb/tb_seg7_factor_reader.sv
// Directed bench for the seven-segment factor reader (STABLE_CYCLES=4,
// FIFO_DEPTH=4). Inputs change 1 time unit after a rising edge; outputs are
// read at that same point. Popped entries are collected at the falling edge.
module tb_seg7_factor_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] segments;
  logic       is_zero;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_zero;
  logic       pattern_err;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  logic [4:0] got_q [$];

  seg7_factor_reader #(
    .STABLE_CYCLES (4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .segments    (segments),
    .is_zero     (is_zero),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_digit   (out_digit),
    .out_zero    (out_zero),
    .pattern_err (pattern_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Record every entry the consumer takes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_digit, out_zero});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] p, input logic z, input int n);
    segments = p;
    is_zero  = z;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic check_entries(input string name, input logic [4:0] exp_q [$]);
    n_vec++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL %s count: got %0d entries, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_vec++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s entry %0d: got %h, expected {digit,zero}=%h", name, i,
                 (i < got_q.size()) ? got_q[i] : 5'h1f, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; segments = 7'h00; is_zero = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL reset out_valid: got %b, expected 0", out_valid); end
    n_vec++; if (out_digit !== 4'h0)   begin n_err++; $display("FAIL reset out_digit: got %h, expected 0", out_digit); end
    n_vec++; if (out_zero !== 1'b0)    begin n_err++; $display("FAIL reset out_zero: got %b, expected 0", out_zero); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL reset pattern_err: got %b, expected 0", pattern_err); end
    n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL reset overflow: got %b, expected 0", overflow); end
    rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    segments = 7'h5B; is_zero = 1'b0;
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency early valid: got %b, expected 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency valid at 5: got %b, expected 1", out_valid); end
    n_vec++; if (out_digit !== 4'h2) begin n_err++; $display("FAIL latency digit: got %h, expected 2", out_digit); end
    tick();
    drive(7'h00, 1'b0, 4);
    check_entries("latency", '{5'b0010_0});
  endtask

  task automatic test_repeat();
    do_reset();
    out_ready = 1'b1;
    drive(7'h5B, 1'b0, 6);
    drive(7'h00, 1'b0, 2);
    drive(7'h5B, 1'b0, 6);
    drive(7'h4F, 1'b1, 6);
    drive(7'h00, 1'b0, 4);
    check_entries("repeat", '{5'b0010_0, 5'b0010_0, 5'b0011_1});
  endtask

  task automatic test_glitch();
    do_reset();
    out_ready = 1'b1;
    drive(7'h4F, 1'b0, 3);
    drive(7'h66, 1'b0, 6);
    drive(7'h00, 1'b0, 4);
    check_entries("glitch", '{5'b0100_0});
  endtask

  task automatic test_invalid();
    do_reset();
    out_ready = 1'b1;
    drive(7'h49, 1'b0, 6);
    drive(7'h00, 1'b0, 4);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL invalid pattern_err: got %b, expected 1", pattern_err); end
    check_entries("invalid", '{});
    drive(7'h06, 1'b0, 6);
    drive(7'h00, 1'b0, 4);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL invalid sticky: got %b, expected 1", pattern_err); end
    check_entries("invalid_then_1", '{5'b0001_0});
  endtask

  task automatic test_overflow();
    logic [6:0] glyphs [5];
    glyphs = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(glyphs[i], 1'b0, 6);
      drive(7'h00, 1'b0, 2);
    end
    n_vec++; if (overflow !== 1'b0)  begin n_err++; $display("FAIL ovf at full: got %b, expected 0", overflow); end
    n_vec++; if (out_digit !== 4'h1) begin n_err++; $display("FAIL ovf head stable: got %h, expected 1", out_digit); end
    drive(glyphs[4], 1'b0, 6);
    drive(7'h00, 1'b0, 2);
    n_vec++; if (overflow !== 1'b1)  begin n_err++; $display("FAIL ovf after 5th: got %b, expected 1", overflow); end
    out_ready = 1'b1;
    repeat (6) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf drained valid: got %b, expected 0", out_valid); end
    check_entries("overflow_drain", '{5'b0001_0, 5'b0010_0, 5'b0011_0, 5'b0100_0});

    // Push lands on the same edge as a pop while full.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(glyphs[i], 1'b0, 6);
      drive(7'h00, 1'b0, 2);
    end
    segments = glyphs[4];
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drive(glyphs[4], 1'b0, 1);
    drive(7'h00, 1'b0, 2);
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL push_pop_full overflow: got %b, expected 0", overflow); end
    out_ready = 1'b1;
    repeat (6) tick();
    check_entries("push_pop_full", '{5'b0001_0, 5'b0010_0, 5'b0011_0, 5'b0100_0, 5'b0101_0});
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    drive(7'h06, 1'b0, 6);
    drive(7'h00, 1'b0, 2);
    drive(7'h49, 1'b0, 6);
    drive(7'h00, 1'b0, 2);
    drive(7'h5B, 1'b0, 6);
    drive(7'h00, 1'b0, 2);
    n_vec++; if (pattern_err !== 1'b1) begin n_err++; $display("FAIL mid pre pattern_err: got %b, expected 1", pattern_err); end
    drive(7'h66, 1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    got_q.delete();
    n_vec++; if (out_valid !== 1'b0)   begin n_err++; $display("FAIL mid out_valid: got %b, expected 0", out_valid); end
    n_vec++; if (pattern_err !== 1'b0) begin n_err++; $display("FAIL mid pattern_err: got %b, expected 0", pattern_err); end
    n_vec++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL mid overflow: got %b, expected 0", overflow); end
    repeat (4) tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid requal early: got %b, expected 0", out_valid); end
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid requal valid: got %b, expected 1", out_valid); end
    n_vec++; if (out_digit !== 4'h4) begin n_err++; $display("FAIL mid requal digit: got %h, expected 4", out_digit); end
    out_ready = 1'b1;
    drive(7'h00, 1'b0, 4);
    check_entries("reset_mid", '{5'b0100_0});
  endtask

  initial begin
    test_reset();
    test_latency();
    test_repeat();
    test_glitch();
    test_invalid();
    test_overflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
